// File: rtl/equal_pattern_gen.sv
// Stimulus source for the equal-half counter: emits target_cnt equal words separated by gap
// non-equal words over valid/ready. First word is valid one cycle after an accepted start.
module equal_pattern_gen #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic [3:0]       gap,
  input  logic             out_ready,
  output logic [3:0]       out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  // An all-zero Fibonacci LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, EQ, NEQ, DONE} state_t;

  state_t           state, state_nx;
  logic [7:0]       lfsr;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] sent;
  logic [3:0]       gap_q;
  logic [3:0]       gap_left;
  logic             accept;
  logic             fire;
  logic [1:0]       h, k_adj;

  assign h        = lfsr[1:0];
  assign k_adj    = (lfsr[3:2] == 2'b00) ? 2'b01 : lfsr[3:2];
  assign fire     = out_ready && ((state == EQ) || (state == NEQ));
  assign accept   = (state == IDLE) && start;
  assign sent_cnt = sent;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out       = 4'b0000;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (target_cnt == '0) ? DONE : EQ;
        end
      end
      EQ: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out       = {h, h};
        if (fire) begin
          if ((sent + 1'b1) == target) begin
            state_nx = DONE;
          end else if (gap_q != 4'd0) begin
            state_nx = NEQ;
          end
        end
      end
      NEQ: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out       = {h, h ^ k_adj};
        if (fire && (gap_left == 4'd1)) begin
          state_nx = EQ;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr     <= SEED;
      target   <= '0;
      gap_q    <= 4'd0;
      gap_left <= 4'd0;
      sent     <= '0;
    end else if (accept) begin
      lfsr   <= SEED;
      target <= target_cnt;
      gap_q  <= gap;
      sent   <= '0;
    end else if (fire) begin
      // Taps 8,6,5,4 feed back into bit 0.
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (state == EQ) begin
        sent     <= sent + 1'b1;
        gap_left <= gap_q;
      end else begin
        gap_left <= gap_left - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_equal_pattern_gen.sv
// Randomized bench for equal_pattern_gen against a word-list reference model.
module tb_equal_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] target_cnt = 8'd0;
  logic [3:0] gap = 4'd0;
  logic       out_ready = 1'b0;
  logic [3:0] out;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [7:0] sent_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  equal_pattern_gen #(.LFSR_SEED(8'hA5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_cnt(target_cnt), .gap(gap),
    .out_ready(out_ready), .out(out), .out_valid(out_valid), .busy(busy),
    .done(done), .sent_cnt(sent_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // rmode: 0 = ready always high, 1 = random ready, 2 = ready pattern 1,0,0,1 then high.
  // restart_cyc >= 0 pulses a conflicting start mid-burst; abort_at >= 0 resets after that many transfers.
  task automatic run_burst(input int tgt, input int gp, input int rmode,
                           input int restart_cyc, input int abort_at);
    logic [3:0] exp_w[$];
    bit         exp_e[$];
    logic [7:0] l;
    logic [1:0] hh, kk;
    logic       r;
    int total, idx, nsent, cyc, eqs;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    l = 8'hA5;
    total = (tgt == 0) ? 0 : tgt + (tgt - 1) * gp;
    for (int p = 0; p < total; p++) begin
      hh = l[1:0];
      kk = (l[3:2] == 2'b00) ? 2'b01 : l[3:2];
      exp_e.push_back((p % (gp + 1)) == 0);
      exp_w.push_back(((p % (gp + 1)) == 0) ? {hh, hh} : {hh, hh ^ kk});
      l = lfsr_step(l);
    end

    start = 1'b1; target_cnt = 8'(tgt); gap = 4'(gp); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; nsent = 0; cyc = 0; eqs = 0;
    while (idx < total) begin
      if (cyc > 5000) begin
        check("timeout", 32'(idx), 32'(total));
        break;
      end
      check("valid", out_valid, 1);
      check("out", out, exp_w[idx]);
      check("busy", busy, 1);
      check("done_mid", done, 0);
      check("sent_mid", sent_cnt, nsent);
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_sent", sent_cnt, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_out", out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_done2", done, 0);
        return;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc < 4) ? pat[cyc] : 1'b1;
      endcase
      if (cyc == restart_cyc) begin
        start = 1'b1; target_cnt = 8'(tgt + 7); gap = 4'($urandom_range(0, 15));
      end
      out_ready = r;
      if (r) begin
        if (out[3:2] == out[1:0]) eqs++;
        if (exp_e[idx]) nsent++;
        idx++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_valid", out_valid, 0);
    check("done_busy", busy, 0);
    check("done_sent", sent_cnt, tgt);
    check("exe8_cnt", eqs, tgt);
    @(negedge clk);
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("hold_sent", sent_cnt, tgt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(3, 1, 0, -1, -1);
    run_burst(0, 5, 0, -1, -1);
    run_burst(2, 0, 2, -1, -1);
    run_burst(4, 2, 0, 3, -1);
    run_burst(10, 1, 0, -1, 3);
    run_burst(3, 1, 0, -1, -1);
    run_burst(255, 0, 0, -1, -1);
    for (int i = 0; i < 8; i++) begin
      run_burst($urandom_range(1, 20), $urandom_range(0, 6), 1, $urandom_range(0, 10), -1);
    end
    // Reset and start asserted together: reset must win.
    start = 1'b1; target_cnt = 8'd5; rst_n = 1'b0;
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    check("rst_vs_start_busy", busy, 0);
    check("rst_vs_start_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
